// File: rtl/ft6206_i2c_target.sv
// ft6206_i2c_target: I2C target serving an FT6206-style touch register file.
// Touch inputs are snapshotted at every START so a burst reads one coherent sample.
`timescale 1ns/1ps
module ft6206_i2c_target #(
  parameter logic [6:0] ADDR        = 7'h38,
  parameter logic [7:0] CHIP_ID     = 8'h06,
  parameter logic [7:0] VENDOR_ID   = 8'h11,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        touch0_valid,
  input  logic [11:0] touch0_x,
  input  logic [11:0] touch0_y,
  input  logic        touch1_valid,
  input  logic [11:0] touch1_x,
  input  logic [11:0] touch1_y,
  output logic [7:0]  dev_mode,
  output logic [7:0]  th_group,
  output logic        busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q, scl_s, sda_s, scl_rise, scl_fall, start, stop;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, dev_mode_q, dev_mode_d, th_group_q, th_group_d;
  logic [7:0] rd_data, wr_byte;
  logic [3:0] cnt_q, cnt_d;
  logic rw_q, rw_d, first_q, first_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic t0v_q, t1v_q;
  logic [11:0] t0x_q, t0y_q, t1x_q, t1y_q;
  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign wr_byte  = {shift_q[6:0], sda_s};
  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign dev_mode = dev_mode_q;
  assign th_group = th_group_q;
  always_comb begin
    rd_data = 8'h00;
    case (ptr_q)
      8'h00: rd_data = dev_mode_q;
      8'h02: rd_data = {6'b0, {1'b0, t0v_q} + {1'b0, t1v_q}};
      8'h03: rd_data = {1'b1, ~t0v_q, 2'b00, t0x_q[11:8]};
      8'h04: rd_data = t0x_q[7:0];
      8'h05: rd_data = {4'h0, t0y_q[11:8]};
      8'h06: rd_data = t0y_q[7:0];
      8'h09: rd_data = {1'b1, ~t1v_q, 2'b00, t1x_q[11:8]};
      8'h0A: rd_data = t1x_q[7:0];
      8'h0B: rd_data = {4'h1, t1y_q[11:8]};
      8'h0C: rd_data = t1y_q[7:0];
      8'h80: rd_data = th_group_q;
      8'hA3: rd_data = CHIP_ID;
      8'hA8: rd_data = VENDOR_ID;
      default: rd_data = 8'h00;
    endcase
  end
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    first_d    = first_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    dev_mode_d = dev_mode_q;
    th_group_d = th_group_q;
    if (start) begin
      state_d  = S_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      first_d  = 1'b1;
    end else if (stop) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = wr_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            rw_d    = sda_s;
            busy_d  = busy_q | (wr_byte[7:1] == ADDR);
            state_d = (wr_byte[7:1] == ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
          end
        end
        // First fall after the 8th bit pulls ACK; the second fall ends it.
        S_ADDR_ACK: if (scl_fall) begin
          cnt_d    = 4'd0;
          sda_oe_d = !sda_oe_q ? 1'b1 : rw_q & ~rd_data[7];
          shift_d  = (sda_oe_q && rw_q) ? rd_data : shift_q;
          state_d  = !sda_oe_q ? S_ADDR_ACK : rw_q ? S_RD_BYTE : S_WR_BYTE;
        end
        S_WR_BYTE: if (scl_rise) begin
          shift_d = wr_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = S_WR_ACK;
            first_d = 1'b0;
            ptr_d   = first_q ? wr_byte : ptr_q + 8'd1;
            if (!first_q && ptr_q == 8'h00) dev_mode_d = wr_byte;
            if (!first_q && ptr_q == 8'h80) th_group_d = wr_byte;
          end
        end
        S_WR_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          state_d  = sda_oe_q ? S_WR_BYTE : S_WR_ACK;
        end
        S_RD_BYTE: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = (cnt_q == 4'd8) ? 1'b0 : ~shift_q[6];
            cnt_d    = (cnt_q == 4'd8) ? 4'd0 : cnt_q;
            state_d  = (cnt_q == 4'd8) ? S_RD_ACK : S_RD_BYTE;
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            state_d = sda_s ? S_WAIT_STOP : S_RD_ACK;
            ptr_d   = sda_s ? ptr_q : ptr_q + 8'd1;
            cnt_d   = sda_s ? 4'd0 : 4'd1;
          end
          if (scl_fall && cnt_q == 4'd1) begin
            cnt_d    = 4'd0;
            shift_d  = rd_data;
            sda_oe_d = ~rd_data[7];
            state_d  = S_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      dev_mode_q <= 8'h00;
      th_group_q <= 8'h80;
      t0v_q      <= 1'b0;
      t1v_q      <= 1'b0;
      t0x_q      <= 12'h000;
      t0y_q      <= 12'h000;
      t1x_q      <= 12'h000;
      t1y_q      <= 12'h000;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      dev_mode_q <= dev_mode_d;
      th_group_q <= th_group_d;
      if (start) begin
        t0v_q <= touch0_valid;
        t1v_q <= touch1_valid;
        t0x_q <= touch0_x;
        t0y_q <= touch0_y;
        t1x_q <= touch1_x;
        t1y_q <= touch1_y;
      end
    end
  end
endmodule
